// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the processor datapath.
// Owns all processor-register enables, memory strobes and datapath mux selects.
module proc_ctrl_fsm #(
    parameter int C_IND = 0,
    parameter int L_IND = 2,
    parameter int F_IND = 5,
    parameter int Z_IND = 6,
    parameter int N_IND = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic [15:0] psr,
    input  logic        mem_rdy,
    output logic        pc_en,
    output logic        instr_en,
    output logic        cmp_f_en,
    output logic        of_f_en,
    output logic        z_f_en,
    output logic        rf_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_DECODE  = 3'b001,
        S_EXEC    = 3'b010,
        S_LOAD    = 3'b011,
        S_STOR    = 3'b100,
        S_BRANCH  = 3'b101,
        S_HALT    = 3'b110,
        S_ILLEGAL = 3'b111
    } state_t;

    state_t state_q, state_d;

    logic [3:0] op, ext, cond, k;
    logic       is_grp4, is_load, is_stor, is_jal, is_jcond, is_halt, is_bcond;
    logic       is_addsub, is_cmp, cond_ok;

    logic       pc_en_c, instr_en_c, cmp_f_en_c, of_f_en_c, z_f_en_c, rf_we_c;
    logic       mem_re_c, mem_we_c, addr_sel_c, halted_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    // Instruction bits outside the decoded fields and PSR bits outside the flag set
    logic unused_ok;
    assign unused_ok = ^{instr[3:0], psr};

    function automatic logic cond_true(input logic [3:0] c, input logic [15:0] p);
        logic fz, fc, fl, ff, fn;
        fz = p[Z_IND];
        fc = p[C_IND];
        fl = p[L_IND];
        ff = p[F_IND];
        fn = p[N_IND];
        case (c)
            4'h0:    cond_true = fz;
            4'h1:    cond_true = !fz;
            4'h2:    cond_true = fc;
            4'h3:    cond_true = !fc;
            4'h4:    cond_true = fl;
            4'h5:    cond_true = !fl;
            4'h6:    cond_true = fn;
            4'h7:    cond_true = !fn;
            4'h8:    cond_true = ff;
            4'h9:    cond_true = !ff;
            4'hA:    cond_true = !fl && !fz;
            4'hB:    cond_true = fl || fz;
            4'hC:    cond_true = !fn && !fz;
            4'hD:    cond_true = fn || fz;
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    assign op   = instr[15:12];
    assign cond = instr[11:8];
    assign ext  = instr[7:4];
    assign k    = (op == 4'b0000) ? ext : op;

    assign is_grp4   = (op == 4'b0100);
    assign is_load   = is_grp4 && (ext == 4'b0000);
    assign is_stor   = is_grp4 && (ext == 4'b0100);
    assign is_jal    = is_grp4 && (ext == 4'b1000);
    assign is_jcond  = is_grp4 && (ext == 4'b1100);
    assign is_halt   = is_grp4 && (ext == 4'b0010);
    assign is_bcond  = (op == 4'b1100);
    assign is_addsub = (k == 4'b0101) || (k == 4'b1001);
    assign is_cmp    = (k == 4'b1011);
    assign cond_ok   = cond_true(cond, psr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en_c    = 1'b0;
        instr_en_c = 1'b0;
        cmp_f_en_c = 1'b0;
        of_f_en_c  = 1'b0;
        z_f_en_c   = 1'b0;
        rf_we_c    = 1'b0;
        mem_re_c   = 1'b0;
        mem_we_c   = 1'b0;
        addr_sel_c = 1'b0;
        halted_c   = 1'b0;
        pc_sel_c   = 2'b00;
        wb_sel_c   = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_re_c = 1'b1;
                if (mem_rdy) begin
                    instr_en_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)                             state_d = S_HALT;
                else if (is_load)                        state_d = S_LOAD;
                else if (is_stor)                        state_d = S_STOR;
                else if (is_bcond || is_jcond || is_jal) state_d = S_BRANCH;
                else                                     state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_we_c    = !is_cmp;
                of_f_en_c  = is_addsub;
                cmp_f_en_c = is_cmp;
                z_f_en_c   = is_cmp;
                pc_en_c    = 1'b1;
                state_d    = S_FETCH;
            end
            S_LOAD: begin
                mem_re_c   = 1'b1;
                addr_sel_c = 1'b1;
                if (mem_rdy) begin
                    rf_we_c  = 1'b1;
                    wb_sel_c = 2'b01;
                    pc_en_c  = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_STOR: begin
                mem_we_c   = 1'b1;
                addr_sel_c = 1'b1;
                if (mem_rdy) begin
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                pc_en_c = 1'b1;
                if (is_jal) begin
                    pc_sel_c = 2'b10;
                    rf_we_c  = 1'b1;
                    wb_sel_c = 2'b10;
                end else if (is_bcond) begin
                    pc_sel_c = cond_ok ? 2'b01 : 2'b00;
                end else if (is_jcond) begin
                    pc_sel_c = cond_ok ? 2'b10 : 2'b00;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset gates every strobe combinationally so an in-flight access dies at once
    assign pc_en    = reset_n & pc_en_c;
    assign instr_en = reset_n & instr_en_c;
    assign cmp_f_en = reset_n & cmp_f_en_c;
    assign of_f_en  = reset_n & of_f_en_c;
    assign z_f_en   = reset_n & z_f_en_c;
    assign rf_we    = reset_n & rf_we_c;
    assign mem_re   = reset_n & mem_re_c;
    assign mem_we   = reset_n & mem_we_c;
    assign addr_sel = reset_n & addr_sel_c;
    assign halted   = reset_n & halted_c;
    assign pc_sel   = reset_n ? pc_sel_c : 2'b00;
    assign wb_sel   = reset_n ? wb_sel_c : 2'b00;
    assign state    = state_q;

endmodule
